// File: rtl/plot_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : plot_pkg
//  Description : Shared state encoding and width helpers for the plot sweep
//                scheduler and its cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package plot_pkg;

   // Sweep FSM state encoding
   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
   localparam logic [STATE_W-1:0] ST_ISSUE       = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT_ACK    = 3'd2;
   localparam logic [STATE_W-1:0] ST_WAIT_RESULT = 3'd3;
   localparam logic [STATE_W-1:0] ST_WRITE       = 3'd4;

   // Width of the column index for a screen of 'hor' active pixels
   function automatic int x_width(input int hor);
      return (hor <= 1) ? 1 : $clog2(hor);
   endfunction

   // Width of the row value for a screen of 'ver' active rows
   function automatic int y_width(input int ver);
      return (ver <= 1) ? 1 : $clog2(ver);
   endfunction

endpackage : plot_pkg
`default_nettype wire

// File: rtl/sweep_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_cycle_counter
//  Description : Saturating clock-cycle counter with synchronous clear and
//                enable, plus a capture register that latches count+1
//                (the count including the capturing cycle itself).
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_cycle_counter #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             enable_i,
   input  logic             capture_i,
   output logic [WIDTH-1:0] captured_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] captured_q;
   logic [WIDTH-1:0] count_inc;

   // Increment that sticks at all-ones instead of wrapping
   assign count_inc = (&count_q) ? count_q : count_q + WIDTH'(1);

   // Counter and capture registers; clear has priority over counting
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q    <= '0;
         captured_q <= '0;
      end else begin
         if (clear_i) begin
            count_q <= '0;
         end else if (enable_i) begin
            count_q <= count_inc;
         end
         if (capture_i) begin
            captured_q <= count_inc;
         end
      end
   end

   assign captured_o = captured_q;

endmodule : sweep_cycle_counter
`default_nettype wire

// File: rtl/plot_sweep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : plot_sweep_scheduler
//  Description : Walks x across every screen column, issues one stack_machine
//                evaluation per column and writes the returned y / skip
//                result into the per-column plot buffer. A new request while
//                busy restarts the sweep from column 0 once the in-flight
//                evaluation has returned.
//  Revision    : 1.0 - initial release
// ============================================================================
module plot_sweep_scheduler
   import plot_pkg::*;
#(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480,
   parameter int CYCLE_COUNT_WIDTH = 24,
   localparam int X_W = x_width(HOR_ACTIVE_PIXELS),
   localparam int Y_W = y_width(VER_ACTIVE_PIXELS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         plot_start,
   output logic                         plot_busy,
   output logic                         plot_done,
   output logic                         sm_start,
   input  logic                         sm_ready,
   output logic [X_W-1:0]               sm_x,
   input  logic [Y_W-1:0]               sm_y,
   input  logic                         sm_skip,
   output logic                         col_we,
   output logic [X_W-1:0]               col_addr,
   output logic [Y_W-1:0]               col_y,
   output logic                         col_valid,
   output logic [CYCLE_COUNT_WIDTH-1:0] last_sweep_cycles
);

   localparam logic [X_W-1:0] X_LAST  = X_W'(HOR_ACTIVE_PIXELS - 1);
   // One extra bit so a power-of-two row count still fits
   localparam logic [Y_W:0]   Y_LIMIT = (Y_W + 1)'(VER_ACTIVE_PIXELS);

   logic [STATE_W-1:0] state_q,   state_d;
   logic [X_W-1:0]     x_q,       x_d;
   logic               restart_q, restart_d;
   logic               busy_q,    busy_d;
   logic [Y_W-1:0]     y_q,       y_d;
   logic               skip_q,    skip_d;

   logic restart_now;
   logic x_last;
   logic pixel_valid;
   logic cnt_clear;
   logic cnt_capture;

   // A request arriving in the WRITE cycle itself counts as a pending restart
   assign restart_now = restart_q | plot_start;
   assign x_last      = (x_q == X_LAST);
   // Off-screen y values that the datapath lets through are drawn as nothing
   assign pixel_valid = !skip_q && ({1'b0, y_q} < Y_LIMIT);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         restart_q <= 1'b0;
         busy_q    <= 1'b0;
         y_q       <= '0;
         skip_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         restart_q <= restart_d;
         busy_q    <= busy_d;
         y_q       <= y_d;
         skip_q    <= skip_d;
      end
   end

   // Next-state and datapath update logic
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      restart_d = restart_q;
      busy_d    = busy_q;
      y_d       = y_q;
      skip_d    = skip_q;
      case (state_q)
         ST_IDLE: begin
            if (plot_start) begin
               state_d   = ST_ISSUE;
               x_d       = '0;
               busy_d    = 1'b1;
               restart_d = 1'b0;
            end
         end
         ST_ISSUE: begin
            // Nothing is in flight yet, so a new request restarts at once
            if (plot_start) begin
               x_d       = '0;
               restart_d = 1'b0;
            end else if (sm_ready) begin
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // Ready is stale this cycle; never look at it here
            if (plot_start) begin
               restart_d = 1'b1;
            end
            state_d = ST_WAIT_RESULT;
         end
         ST_WAIT_RESULT: begin
            if (plot_start) begin
               restart_d = 1'b1;
            end
            if (sm_ready) begin
               y_d     = sm_y;
               skip_d  = sm_skip;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (restart_now) begin
               x_d       = '0;
               restart_d = 1'b0;
               state_d   = ST_ISSUE;
            end else if (x_last) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               x_d     = x_q + X_W'(1);
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode: start pulse, buffer write strobe, done pulse, counter control
   always_comb begin
      sm_start    = 1'b0;
      col_we      = 1'b0;
      col_y       = '0;
      col_valid   = 1'b0;
      plot_done   = 1'b0;
      cnt_clear   = 1'b0;
      cnt_capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clear = plot_start;
         end
         ST_ISSUE: begin
            if (plot_start) begin
               cnt_clear = 1'b1;
            end else begin
               sm_start = sm_ready;
            end
         end
         ST_WRITE: begin
            if (restart_now) begin
               cnt_clear = 1'b1;
            end else begin
               col_we    = 1'b1;
               col_valid = pixel_valid;
               col_y     = pixel_valid ? y_q : '0;
               if (x_last) begin
                  plot_done   = 1'b1;
                  cnt_capture = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign sm_x      = x_q;
   assign col_addr  = x_q;
   assign plot_busy = busy_q;

   sweep_cycle_counter #(
      .WIDTH (CYCLE_COUNT_WIDTH)
   ) u_cycle_counter (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (cnt_clear),
      .enable_i   (busy_q),
      .capture_i  (cnt_capture),
      .captured_o (last_sweep_cycles)
   );

endmodule : plot_sweep_scheduler
`default_nettype wire

// File: tb/tb_plot_sweep_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plot_sweep_scheduler
//  Description : Self-checking bench for plot_sweep_scheduler with a
//                behavioural stack_machine model (per-column latency and
//                result tables) and a reference model of the expected
//                plot-buffer writes and sweep duration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plot_sweep_scheduler;

   localparam int HOR = 8;
   localparam int VER = 480;
   localparam int CW  = 24;
   localparam int XW  = 3;
   localparam int YW  = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          plot_start;
   logic          plot_busy;
   logic          plot_done;
   logic          sm_start;
   logic          sm_ready;
   logic [XW-1:0] sm_x;
   logic [YW-1:0] sm_y;
   logic          sm_skip;
   logic          col_we;
   logic [XW-1:0] col_addr;
   logic [YW-1:0] col_y;
   logic          col_valid;
   logic [CW-1:0] last_sweep_cycles;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   plot_sweep_scheduler #(
      .HOR_ACTIVE_PIXELS (HOR),
      .VER_ACTIVE_PIXELS (VER),
      .CYCLE_COUNT_WIDTH (CW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .plot_start        (plot_start),
      .plot_busy         (plot_busy),
      .plot_done         (plot_done),
      .sm_start          (sm_start),
      .sm_ready          (sm_ready),
      .sm_x              (sm_x),
      .sm_y              (sm_y),
      .sm_skip           (sm_skip),
      .col_we            (col_we),
      .col_addr          (col_addr),
      .col_y             (col_y),
      .col_valid         (col_valid),
      .last_sweep_cycles (last_sweep_cycles)
   );

   // ---------------- stack_machine model (not affected by DUT reset) -----------
   logic [YW-1:0] y_tab    [HOR];
   bit            skip_tab [HOR];
   int            lat_tab  [HOR];
   bit            hold = 1'b0;
   int            cnt  = 0;
   logic [XW-1:0] mx   = '0;
   int            lost_starts = 0;

   assign sm_ready = (cnt == 0) && !hold;
   assign sm_y     = y_tab[mx];
   assign sm_skip  = skip_tab[mx];

   always @(posedge clk) begin
      if (sm_start && !sm_ready) lost_starts++;
      if (cnt > 0) cnt--;
      else if (sm_start && sm_ready) begin
         cnt = lat_tab[sm_x];
         mx  = sm_x;
      end
   end

   // ---------------- monitor ----------------
   logic [XW-1:0] wr_addr  [$];
   logic [YW-1:0] wr_y     [$];
   logic          wr_valid [$];
   logic [XW-1:0] st_x     [$];
   int            done_n     = 0;
   int            dbl_start  = 0;
   logic          prev_start = 1'b0;

   always @(negedge clk) begin
      if (col_we) begin
         wr_addr.push_back(col_addr);
         wr_y.push_back(col_y);
         wr_valid.push_back(col_valid);
      end
      if (sm_start) st_x.push_back(sm_x);
      if (sm_start && prev_start) dbl_start++;
      prev_start = sm_start;
      if (plot_done) done_n++;
   end

   // ---------------- reference model ----------------
   function automatic logic exp_valid(input int x);
      return !skip_tab[x] && (int'(y_tab[x]) < VER);
   endfunction

   function automatic logic [YW-1:0] exp_y(input int x);
      return exp_valid(x) ? y_tab[x] : '0;
   endfunction

   // issue + ack + compute + write for every column
   function automatic int exp_cycles();
      int s = 0;
      for (int i = 0; i < HOR; i++) s += lat_tab[i] + 3;
      return s;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      plot_start = 1'b1;
      tick();
      plot_start = 1'b0;
   endtask

   task automatic load_fixed();
      for (int i = 0; i < HOR; i++) begin
         y_tab[i]    = YW'(i % VER);
         skip_tab[i] = 1'b0;
         lat_tab[i]  = 10;
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < HOR; i++) begin
         lat_tab[i]  = int'($urandom_range(1, 12));
         y_tab[i]    = YW'($urandom_range(0, 511));
         skip_tab[i] = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (plot_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_start_x(input logic [XW-1:0] xv, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (sm_start && sm_x == xv) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      plot_start = 1'b1;
      repeat (3) tick();
      plot_start = 1'b0;
      checks++;
      if ({plot_busy, plot_done, sm_start, col_we, col_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b done=%b start=%b we=%b valid=%b, want all 0",
                  plot_busy, plot_done, sm_start, col_we, col_valid);
      end
      checks++;
      if (col_addr !== '0 || col_y !== '0 || sm_x !== '0) begin
         errors++;
         $display("FAIL reset_addr: got addr=%0d y=%0d sm_x=%0d, want 0", col_addr, col_y, sm_x);
      end
      checks++;
      if (last_sweep_cycles !== '0) begin
         errors++;
         $display("FAIL reset_last: got %0d, want 0", last_sweep_cycles);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (plot_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_start_ignored: got busy=%b, want 0", plot_busy);
      end
   endtask

   task automatic test_basic_sweep();
      int ws = wr_addr.size();
      int ss = st_x.size();
      int dn = done_n;
      bit ok;
      load_fixed();
      pulse_start();
      checks++;
      if (plot_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b, want 1", plot_busy);
      end
      wait_done(2000, ok);
      tick();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_timeout: got no plot_done, want one");
      end
      checks++;
      if (wr_addr.size() - ws != HOR) begin
         errors++;
         $display("FAIL basic_nwrites: got %0d, want %0d", wr_addr.size() - ws, HOR);
      end else begin
         for (int i = 0; i < HOR; i++) begin
            checks++;
            if (wr_addr[ws+i] !== XW'(i) || wr_y[ws+i] !== exp_y(i) || wr_valid[ws+i] !== exp_valid(i)) begin
               errors++;
               $display("FAIL basic_col%0d: got addr=%0d y=%0d v=%b, want addr=%0d y=%0d v=%b",
                        i, wr_addr[ws+i], wr_y[ws+i], wr_valid[ws+i], i, exp_y(i), exp_valid(i));
            end
         end
      end
      checks++;
      if (last_sweep_cycles !== CW'(104)) begin
         errors++;
         $display("FAIL basic_cycles: got %0d, want 104", last_sweep_cycles);
      end
      checks++;
      if (done_n - dn != 1 || st_x.size() - ss != HOR || plot_busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_counts: got done=%0d starts=%0d busy=%b, want 1 %0d 0",
                  done_n - dn, st_x.size() - ss, plot_busy, HOR);
      end
   endtask

   task automatic test_skip_offscreen();
      int ws = wr_addr.size();
      bit ok;
      load_random();
      skip_tab[3] = 1'b1;
      y_tab[5]    = YW'(VER);
      skip_tab[5] = 1'b0;
      y_tab[6]    = YW'(VER - 1);
      skip_tab[6] = 1'b0;
      pulse_start();
      wait_done(2000, ok);
      tick();
      checks++;
      if (!ok || wr_addr.size() - ws != HOR) begin
         errors++;
         $display("FAIL skip_sweep: got done=%b writes=%0d, want 1 %0d", ok, wr_addr.size() - ws, HOR);
      end else begin
         for (int i = 0; i < HOR; i++) begin
            checks++;
            if (wr_addr[ws+i] !== XW'(i) || wr_y[ws+i] !== exp_y(i) || wr_valid[ws+i] !== exp_valid(i)) begin
               errors++;
               $display("FAIL skip_col%0d: got addr=%0d y=%0d v=%b, want addr=%0d y=%0d v=%b",
                        i, wr_addr[ws+i], wr_y[ws+i], wr_valid[ws+i], i, exp_y(i), exp_valid(i));
            end
         end
      end
      checks++;
      if (last_sweep_cycles !== CW'(exp_cycles())) begin
         errors++;
         $display("FAIL skip_cycles: got %0d, want %0d", last_sweep_cycles, exp_cycles());
      end
   endtask

   task automatic test_restart_mid();
      int ws = wr_addr.size();
      int ss = st_x.size();
      int dn = done_n;
      bit ok;
      bit ok2;
      load_fixed();
      pulse_start();
      wait_start_x(XW'(4), ok);
      repeat (3) tick();
      pulse_start();
      wait_done(2000, ok2);
      tick();
      checks++;
      if (!ok || !ok2) begin
         errors++;
         $display("FAIL restart_timeout: got x4_seen=%b done=%b, want 1 1", ok, ok2);
      end
      checks++;
      if (wr_addr.size() - ws != 4 + HOR || st_x.size() - ss != 5 + HOR) begin
         errors++;
         $display("FAIL restart_counts: got writes=%0d starts=%0d, want %0d %0d",
                  wr_addr.size() - ws, st_x.size() - ss, 4 + HOR, 5 + HOR);
      end else begin
         for (int i = 0; i < 4 + HOR; i++) begin
            checks++;
            if (wr_addr[ws+i] !== XW'((i < 4) ? i : i - 4)) begin
               errors++;
               $display("FAIL restart_write%0d: got addr=%0d, want %0d", i, wr_addr[ws+i], (i < 4) ? i : i - 4);
            end
         end
         for (int i = 0; i < 5 + HOR; i++) begin
            checks++;
            if (st_x[ss+i] !== XW'((i < 5) ? i : i - 5)) begin
               errors++;
               $display("FAIL restart_issue%0d: got sm_x=%0d, want %0d", i, st_x[ss+i], (i < 5) ? i : i - 5);
            end
         end
      end
      checks++;
      if (done_n - dn != 1 || last_sweep_cycles !== CW'(104)) begin
         errors++;
         $display("FAIL restart_done: got done=%0d cycles=%0d, want 1 104", done_n - dn, last_sweep_cycles);
      end
   endtask

   task automatic test_final_write_restart();
      int ws = wr_addr.size();
      int dn = done_n;
      bit ok;
      bit ok2;
      load_fixed();
      pulse_start();
      wait_start_x(XW'(HOR - 1), ok);
      repeat (lat_tab[HOR-1] + 2) tick();
      checks++;
      if (col_we !== 1'b1 || col_addr !== XW'(HOR - 1)) begin
         errors++;
         $display("FAIL final_write_reached: got we=%b addr=%0d, want 1 %0d", col_we, col_addr, HOR - 1);
      end
      plot_start = 1'b1;
      #1;
      checks++;
      if (col_we !== 1'b0 || plot_done !== 1'b0) begin
         errors++;
         $display("FAIL final_write_suppress: got we=%b done=%b, want 0 0", col_we, plot_done);
      end
      tick();
      plot_start = 1'b0;
      wait_done(2000, ok2);
      tick();
      checks++;
      if (!ok || !ok2 || done_n - dn != 1 || wr_addr.size() - ws != 2 * HOR - 1) begin
         errors++;
         $display("FAIL final_restart: got x7=%b done=%b dones=%0d writes=%0d, want 1 1 1 %0d",
                  ok, ok2, done_n - dn, wr_addr.size() - ws, 2 * HOR - 1);
      end else begin
         for (int i = 0; i < 2 * HOR - 1; i++) begin
            checks++;
            if (wr_addr[ws+i] !== XW'((i < HOR - 1) ? i : i - (HOR - 1))) begin
               errors++;
               $display("FAIL final_write%0d: got addr=%0d, want %0d", i, wr_addr[ws+i],
                        (i < HOR - 1) ? i : i - (HOR - 1));
            end
         end
      end
      checks++;
      if (last_sweep_cycles !== CW'(104)) begin
         errors++;
         $display("FAIL final_cycles: got %0d, want 104", last_sweep_cycles);
      end
   endtask

   task automatic test_mid_reset();
      int ws;
      int ss;
      int ls;
      bit ok;
      bit ok2;
      load_fixed();
      pulse_start();
      wait_start_x(XW'(2), ok);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (plot_busy !== 1'b0 || sm_start !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idle: got busy=%b start=%b, want 0 0", plot_busy, sm_start);
      end
      ws = wr_addr.size();
      ss = st_x.size();
      ls = lost_starts;
      pulse_start();
      wait_done(2000, ok2);
      tick();
      checks++;
      if (!ok || !ok2 || lost_starts != ls) begin
         errors++;
         $display("FAIL midreset_run: got x2=%b done=%b lost=%0d, want 1 1 0", ok, ok2, lost_starts - ls);
      end
      checks++;
      if (st_x.size() - ss != HOR || wr_addr.size() - ws != HOR) begin
         errors++;
         $display("FAIL midreset_counts: got starts=%0d writes=%0d, want %0d %0d",
                  st_x.size() - ss, wr_addr.size() - ws, HOR, HOR);
      end else begin
         for (int i = 0; i < HOR; i++) begin
            checks++;
            if (st_x[ss+i] !== XW'(i) || wr_addr[ws+i] !== XW'(i)) begin
               errors++;
               $display("FAIL midreset_col%0d: got sm_x=%0d addr=%0d, want %0d", i, st_x[ss+i], wr_addr[ws+i], i);
            end
         end
      end
      // first ISSUE waits 4 extra cycles for the model's leftover compute
      checks++;
      if (last_sweep_cycles !== CW'(104 + 4)) begin
         errors++;
         $display("FAIL midreset_cycles: got %0d, want 108", last_sweep_cycles);
      end
   endtask

   task automatic test_ready_hold();
      int ws = wr_addr.size();
      int ss = st_x.size();
      bit ok;
      load_fixed();
      hold = 1'b1;
      pulse_start();
      repeat (50) tick();
      checks++;
      if (st_x.size() != ss || plot_busy !== 1'b1) begin
         errors++;
         $display("FAIL hold_nostart: got starts=%0d busy=%b, want 0 1", st_x.size() - ss, plot_busy);
      end
      hold = 1'b0;
      wait_done(2000, ok);
      tick();
      checks++;
      if (!ok || wr_addr.size() - ws != HOR || st_x.size() - ss != HOR) begin
         errors++;
         $display("FAIL hold_sweep: got done=%b writes=%0d starts=%0d, want 1 %0d %0d",
                  ok, wr_addr.size() - ws, st_x.size() - ss, HOR, HOR);
      end
      checks++;
      if (last_sweep_cycles !== CW'(104 + 50)) begin
         errors++;
         $display("FAIL hold_cycles: got %0d, want 154", last_sweep_cycles);
      end
   endtask

   task automatic test_back_to_back();
      for (int s = 0; s < 3; s++) begin
         int ws = wr_addr.size();
         bit ok;
         load_random();
         pulse_start();
         wait_done(2000, ok);
         tick();
         checks++;
         if (!ok || wr_addr.size() - ws != HOR) begin
            errors++;
            $display("FAIL b2b_sweep%0d: got done=%b writes=%0d, want 1 %0d", s, ok, wr_addr.size() - ws, HOR);
         end else begin
            for (int i = 0; i < HOR; i++) begin
               checks++;
               if (wr_addr[ws+i] !== XW'(i) || wr_y[ws+i] !== exp_y(i) || wr_valid[ws+i] !== exp_valid(i)) begin
                  errors++;
                  $display("FAIL b2b%0d_col%0d: got addr=%0d y=%0d v=%b, want addr=%0d y=%0d v=%b",
                           s, i, wr_addr[ws+i], wr_y[ws+i], wr_valid[ws+i], i, exp_y(i), exp_valid(i));
               end
            end
         end
         checks++;
         if (last_sweep_cycles !== CW'(exp_cycles())) begin
            errors++;
            $display("FAIL b2b_cycles%0d: got %0d, want %0d", s, last_sweep_cycles, exp_cycles());
         end
      end
   endtask

   task automatic test_start_width();
      checks++;
      if (dbl_start != 0 || lost_starts != 0) begin
         errors++;
         $display("FAIL start_width: got double=%0d unready=%0d, want 0 0", dbl_start, lost_starts);
      end
   endtask

   initial begin
      rst        = 1'b1;
      plot_start = 1'b0;
      load_fixed();
      test_reset();
      test_basic_sweep();
      test_skip_offscreen();
      test_restart_mid();
      test_final_write_restart();
      test_mid_reset();
      test_ready_hold();
      test_back_to_back();
      test_start_width();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_plot_sweep_scheduler
`default_nettype wire
